blast_fsm: RTL and testbench

- Downstream consumer of the bomb/mine FSM's `bomb_exploded` and top-left position outputs.
- On each rising edge of `bomb_exploded` it runs a frame-timed blast animation: a cross of tiles centred on the bomb tile grows, holds, then shrinks.
- Produces a per-pixel blast draw request for the VGA object mux, plus status outputs for collision and game logic.

---
 rtl/blast_fsm.sv | 176 +++++++++++++++++
 tb/tb_blast_fsm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/blast_fsm.sv
// Blast animation FSM: a cross of tiles around the bomb tile grows, holds, then shrinks, with a registered pixel draw request.
// Optional: define BLAST_FLICKER_EN to make the blast blink on alternate frames while shrinking.
module blast_fsm #(
    parameter int TILE_SIZE       = 32,
    parameter int MAX_RADIUS      = 3,
    parameter int FRAMES_PER_STEP = 4,
    parameter int HOLD_FRAMES     = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               bomb_exploded,
    input  logic signed [10:0] bombTopLeftX,
    input  logic signed [10:0] bombTopLeftY,
    input  logic        [10:0] pixelX,
    input  logic        [10:0] pixelY,
    output logic               blastDrawingRequest,
    output logic               blast_active,
    output logic        [3:0]  blast_radius,
    output logic        [1:0]  blast_phase,
    output logic               blast_done
);

    typedef enum logic [2:0] {S_IDLE, S_GROW, S_HOLD, S_SHRINK, S_DONE} state_t;

    localparam int SHIFT    = $clog2(TILE_SIZE);
    localparam int CNT_MAX  = (HOLD_FRAMES > FRAMES_PER_STEP) ? HOLD_FRAMES : FRAMES_PER_STEP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]        MAX_R     = 4'(MAX_RADIUS);
    localparam logic signed [11:0] TILE12   = 12'(TILE_SIZE);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         radius, radius_n;
    logic signed [10:0] cx, cx_n, cy, cy_n;
    logic               bomb_d;
    logic               trigger;
    logic               draw_n;
    logic               flicker_gate;

    assign trigger = bomb_exploded & ~bomb_d;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            radius              <= '0;
            cx                  <= '0;
            cy                  <= '0;
            bomb_d              <= 1'b0;
            blastDrawingRequest <= 1'b0;
        end else begin
            state               <= state_n;
            cnt                 <= cnt_n;
            radius              <= radius_n;
            cx                  <= cx_n;
            cy                  <= cy_n;
            bomb_d              <= bomb_exploded;
            blastDrawingRequest <= draw_n;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred on untaken paths.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        radius_n = radius;
        cx_n     = cx;
        cy_n     = cy;
        unique case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_n  = S_GROW;
                    cnt_n    = '0;
                    radius_n = '0;
                    cx_n     = bombTopLeftX;
                    cy_n     = bombTopLeftY;
                end
            end
            S_GROW: begin
                if (startOfFrame) begin
                    if (cnt == STEP_LAST) begin
                        cnt_n    = '0;
                        radius_n = radius + 4'd1;
                        if (radius + 4'd1 == MAX_R)
                            state_n = S_HOLD;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            S_HOLD: begin
                if (startOfFrame) begin
                    if (cnt == HOLD_LAST) begin
                        cnt_n   = '0;
                        state_n = S_SHRINK;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            S_SHRINK: begin
                if (startOfFrame) begin
                    if (cnt == STEP_LAST) begin
                        cnt_n = '0;
                        if (radius == 4'd0)
                            state_n = S_DONE;
                        else
                            radius_n = radius - 4'd1;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            S_DONE: begin
                state_n  = S_IDLE;
                radius_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        blast_active = 1'b0;
        blast_phase  = 2'd0;
        blast_done   = 1'b0;
        unique case (state)
            S_GROW:   begin blast_active = 1'b1; blast_phase = 2'd1; end
            S_HOLD:   begin blast_active = 1'b1; blast_phase = 2'd2; end
            S_SHRINK: begin blast_active = 1'b1; blast_phase = 2'd3; end
            S_DONE:   blast_done = 1'b1;
            default:  ;
        endcase
    end

    assign blast_radius = radius;

`ifdef BLAST_FLICKER_EN
    logic flicker, flicker_n;

    // Cleared whenever not shrinking, so it always starts at 0 on entry to SHRINK.
    assign flicker_n    = (state == S_SHRINK) ? (flicker ^ startOfFrame) : 1'b0;
    assign flicker_gate = ~flicker;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) flicker <= 1'b0;
        else         flicker <= flicker_n;
    end
`else
    assign flicker_gate = 1'b1;
`endif

    // Cross geometry in 12-bit signed space: centre tile plus r tiles on each side.
    logic signed [11:0] x0, y0, px, py, arm_lo, arm_hi;
    logic               in_h, in_v;

    always_comb begin
        x0     = {cx[10], cx};
        y0     = {cy[10], cy};
        px     = {1'b0, pixelX};
        py     = {1'b0, pixelY};
        arm_lo = 12'(radius) << SHIFT;
        arm_hi = arm_lo + TILE12;
        in_h   = (py >= y0) && (py < y0 + TILE12) &&
                 (px >= x0 - arm_lo) && (px < x0 + arm_hi);
        in_v   = (px >= x0) && (px < x0 + TILE12) &&
                 (py >= y0 - arm_lo) && (py < y0 + arm_hi);
        draw_n = blast_active && (in_h || in_v) && flicker_gate;
    end

endmodule

// File: tb/tb_blast_fsm.sv
// Self-checking bench for blast_fsm: directed timing/geometry tables plus randomized traffic against a pulse-count model.
module tb_blast_fsm;

    localparam int T     = 32;
    localparam int MAXR  = 3;
    localparam int FPS   = 4;
    localparam int HOLDF = 30;
    localparam int T_HOLD = FPS * MAXR;
    localparam int T1     = T_HOLD + HOLDF;
    localparam int TEND   = T1 + FPS * (MAXR + 1);

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               sof = 1'b0;
    logic               bomb = 1'b0;
    logic signed [10:0] bx = '0;
    logic signed [10:0] by = '0;
    logic        [10:0] px = '0;
    logic        [10:0] py = '0;
    logic               draw;
    logic               active;
    logic        [3:0]  radius;
    logic        [1:0]  phase;
    logic               done;

    blast_fsm dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (sof),
        .bomb_exploded       (bomb),
        .bombTopLeftX        (bx),
        .bombTopLeftY        (by),
        .pixelX              (px),
        .pixelY              (py),
        .blastDrawingRequest (draw),
        .blast_active        (active),
        .blast_radius        (radius),
        .blast_phase         (phase),
        .blast_done          (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the whole sequence is a function of frame pulses counted since the trigger.
    bit m_busy = 0, m_done = 0, m_prev = 0;
    int m_k = 0, m_cx = 0, m_cy = 0;
    bit m_draw = 0;

    bit cur_bomb = 0;
    int cur_px = 0, cur_py = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_phase();
        if (!m_busy)     return 0;
        if (m_k < T_HOLD) return 1;
        if (m_k < T1)     return 2;
        return 3;
    endfunction

    function automatic int m_radius();
        if (!m_busy)      return 0;
        if (m_k < T_HOLD) return m_k / FPS;
        if (m_k < T1)     return MAXR;
        return MAXR - (m_k - T1) / FPS;
    endfunction

    function automatic bit m_hit(int r, int cx, int cy, int x, int y);
        bit h, v;
        h = (y >= cy) && (y < cy + T) && (x >= cx - r * T) && (x < cx + (r + 1) * T);
        v = (x >= cx) && (x < cx + T) && (y >= cy - r * T) && (y < cy + (r + 1) * T);
        return h || v;
    endfunction

    function automatic bit m_flick_ok();
`ifdef BLAST_FLICKER_EN
        if (m_busy && m_k >= T1) return ((m_k - T1) % 2) == 0;
`endif
        return 1'b1;
    endfunction

    task automatic step(input bit s, input bit b, input int x, input int y);
        sof  = s;
        bomb = b;
        px   = 11'(x);
        py   = 11'(y);
        @(posedge clk);
        m_draw = m_busy && m_hit(m_radius(), m_cx, m_cy, x, y) && m_flick_ok();
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (b && !m_prev) begin
                m_busy = 1;
                m_k    = 0;
                m_cx   = int'(bx);
                m_cy   = int'(by);
            end
        end else if (s) begin
            m_k++;
            if (m_k == TEND) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        m_prev = b;
        #1;
        check("phase",  phase,  m_phase());
        check("radius", radius, m_radius());
        check("active", active, m_busy);
        check("done",   done,   m_done);
        check("draw",   draw,   m_draw);
    endtask

    task automatic tick(input bit s);
        step(s, cur_bomb, cur_px, cur_py);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    typedef struct {
        int x;
        int y;
        bit exp;
    } geom_t;

    geom_t gt[14];

    initial begin
        int ox, oy;
        bit s;

        // Radius 2 around tile (320,224): arms span x 256..415 and y 160..319.
        gt[0]  = '{256, 240, 1'b1};
        gt[1]  = '{255, 240, 1'b0};
        gt[2]  = '{383, 240, 1'b1};
        gt[3]  = '{384, 240, 1'b1};
        gt[4]  = '{415, 240, 1'b1};
        gt[5]  = '{416, 240, 1'b0};
        gt[6]  = '{330, 160, 1'b1};
        gt[7]  = '{330, 159, 1'b0};
        gt[8]  = '{330, 319, 1'b1};
        gt[9]  = '{330, 320, 1'b0};
        gt[10] = '{290, 200, 1'b0};
        gt[11] = '{300, 250, 1'b1};
        gt[12] = '{351, 255, 1'b1};
        gt[13] = '{352, 256, 1'b0};

        // Reset state.
        #12;
        check("rst_phase",  phase,  0);
        check("rst_radius", radius, 0);
        check("rst_active", active, 0);
        check("rst_done",   done,   0);
        check("rst_draw",   draw,   0);
        resetN = 1'b1;

        // Full sequence with milestones checked against absolute pulse numbers.
        bx = 11'sd320; by = 11'sd224;
        cur_px = 330; cur_py = 240;
        idle(2);
        cur_bomb = 1'b1;
        tick(1'b0);
        check("trig_phase",  phase,  1);
        check("trig_radius", radius, 0);
        for (int p = 1; p <= TEND; p++) begin
            tick(1'b1);
            case (p)
                4:  check("p4_radius",  radius, 1);
                8:  check("p8_radius",  radius, 2);
                12: begin check("p12_radius", radius, 3); check("p12_phase", phase, 2); end
                41: check("p41_phase",  phase,  2);
                42: check("p42_phase",  phase,  3);
                46: check("p46_radius", radius, 2);
                50: check("p50_radius", radius, 1);
                53: check("p53_radius", radius, 1);
                54: check("p54_radius", radius, 0);
                57: check("p57_done",   done,   0);
                58: check("p58_done",   done,   1);
                default: ;
            endcase
            if (p == 8) begin
                for (int i = 0; i < 14; i++) begin
                    step(1'b0, cur_bomb, gt[i].x, gt[i].y);
                    check($sformatf("geom_%0d_%0d", gt[i].x, gt[i].y), draw, gt[i].exp);
                end
            end
            if (p == 20) begin
                cur_bomb = 1'b0; tick(1'b0);
                cur_bomb = 1'b1; tick(1'b0);
            end
            idle(2);
            if (p == 43 || p == 44) begin
`ifdef BLAST_FLICKER_EN
                check("flicker_draw", draw, (p == 44) ? 1 : 0);
`else
                check("shrink_draw", draw, 1);
`endif
            end
            if (p == 58) begin
                check("post_phase",  phase,  0);
                check("post_done",   done,   0);
                check("post_active", active, 0);
                check("post_draw",   draw,   0);
            end
        end

        // New rising edge after completion; centre change mid-GROW is ignored; then async reset.
        cur_bomb = 1'b0; idle(1);
        cur_bomb = 1'b1; tick(1'b0);
        check("retrig_phase", phase, 1);
        bx = 11'sd100; by = 11'sd100;
        step(1'b0, 1'b1, 330, 240);
        check("latched_old", draw, 1);
        step(1'b0, 1'b1, 110, 110);
        check("latched_new", draw, 0);
        for (int p = 0; p < 5; p++) begin tick(1'b1); idle(1); end
        check("pre_rst_radius", radius, 1);
        #2 resetN = 1'b0;
        #1;
        check("arst_phase",  phase,  0);
        check("arst_radius", radius, 0);
        check("arst_active", active, 0);
        check("arst_done",   done,   0);
        check("arst_draw",   draw,   0);
        m_busy = 0; m_done = 0; m_prev = 0;
        @(posedge clk);
        #3;
        cur_bomb = 1'b0; bomb = 1'b0;
        resetN = 1'b1;
        idle(2);

        // Trigger coincident with a frame pulse: that pulse is not counted.
        bx = 11'sd40; by = 11'sd8;
        cur_px = 45; cur_py = 10;
        cur_bomb = 1'b1; tick(1'b1);
        check("coinc_phase", phase, 1);
        for (int p = 1; p <= 4; p++) begin
            tick(1'b1);
            check($sformatf("coinc_radius_%0d", p), radius, (p == 4) ? 1 : 0);
            idle(1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 29) == 0) cur_bomb = ~cur_bomb;
            if ($urandom_range(0, 49) == 0) begin
                bx = 11'($urandom_range(0, 2047));
                by = 11'($urandom_range(0, 2047));
            end
            s  = ($urandom_range(0, 2) == 0);
            ox = int'($urandom_range(0, 450)) - 200;
            oy = int'($urandom_range(0, 450)) - 200;
            step(s, cur_bomb, (m_cx + ox) & 2047, (m_cy + oy) & 2047);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
